acia_uart: RTL and testbench

//  Memory-mapped serial port: the bus responder at CPU page $2xxx (cs_acia).

---
 rtl/acia_uart_pkg.sv | 24 ++
 rtl/acia_uart_rx_core.sv | 91 +++++++++
 rtl/acia_uart.sv | 142 ++++++++++++++
 tb/tb_acia_uart.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/acia_uart_pkg.sv
// Shared definitions for the ACIA serial port: register map, STATUS/CTRL bit
// positions and the state encoding used by both the TX and RX sequencers.
package acia_uart_pkg;

   localparam logic ACIA_REG_STAT = 1'b0;
   localparam logic ACIA_REG_DATA = 1'b1;

   localparam int unsigned STAT_RX_FULL  = 0;
   localparam int unsigned STAT_TX_EMPTY = 1;
   localparam int unsigned STAT_FERR     = 2;
   localparam int unsigned STAT_OVR      = 3;
   localparam int unsigned STAT_IRQ      = 7;

   localparam int unsigned CTRL_RX_IRQ_EN = 0;
   localparam int unsigned CTRL_TX_IRQ_EN = 1;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_START = 2'd1,
      ST_DATA  = 2'd2,
      ST_STOP  = 2'd3
   } frame_state_t;

endpackage

// File: rtl/acia_uart_rx_core.sv
// 8N1 receiver: 2-FF input synchroniser, mid-bit sampling sequencer and baud
// counter. Emits a one-clock rx_valid pulse with the byte and framing status.
module uart_rx_core
   import acia_uart_pkg::*;
#(
   parameter int unsigned BAUD_DIV = 104
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       rx,
   output logic [7:0] rx_byte,
   output logic       rx_valid,
   output logic       rx_ferr
);

   localparam int unsigned CW = $clog2(BAUD_DIV) + 1;
   localparam logic [CW-1:0] FULL = CW'(BAUD_DIV - 1);
   localparam logic [CW-1:0] HALF = CW'(BAUD_DIV / 2 - 1);

   logic [1:0]    sync_q;
   logic          rx_s;
   frame_state_t  state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [2:0]    bit_q, bit_d;
   logic [7:0]    shift_q, shift_d;
   logic          valid_d, ferr_d;

   assign rx_s    = sync_q[1];
   assign rx_byte = shift_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         sync_q   <= '1;
         state_q  <= ST_IDLE;
         cnt_q    <= '0;
         bit_q    <= '0;
         shift_q  <= '0;
         rx_valid <= 1'b0;
         rx_ferr  <= 1'b0;
      end else begin
         sync_q   <= {sync_q[0], rx};
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         bit_q    <= bit_d;
         shift_q  <= shift_d;
         rx_valid <= valid_d;
         rx_ferr  <= ferr_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      bit_d   = bit_q;
      shift_d = shift_q;
      valid_d = 1'b0;
      ferr_d  = rx_ferr;
      if (state_q == ST_IDLE) begin
         if (!rx_s) begin
            state_d = ST_START;
            cnt_d   = HALF;
         end
      end else if (cnt_q != '0) begin
         cnt_d = cnt_q - CW'(1);
      end else begin
         // Half-bit offset from START keeps every later sample at mid-bit
         cnt_d = FULL;
         case (state_q)
            ST_START: begin
               if (rx_s) state_d = ST_IDLE;
               else begin
                  state_d = ST_DATA;
                  bit_d   = '0;
               end
            end
            ST_DATA: begin
               shift_d = {rx_s, shift_q[7:1]};
               if (bit_q == 3'd7) state_d = ST_STOP;
               else bit_d = bit_q + 3'd1;
            end
            ST_STOP: begin
               state_d = ST_IDLE;
               valid_d = 1'b1;
               ferr_d  = ~rx_s;
            end
            default: state_d = ST_IDLE;
         endcase
      end
   end

endmodule

// File: rtl/acia_uart.sv
// Memory-mapped 8N1 serial port: STATUS/CTRL and DATA registers, transmit
// sequencer, level interrupt and registered read data.
module acia_uart
   import acia_uart_pkg::*;
#(
   parameter int unsigned BAUD_DIV = 104
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       cs,
   input  logic       we,
   input  logic       rs,
   input  logic [7:0] din,
   output logic [7:0] dout,
   input  logic       rx,
   output logic       tx,
   output logic       irq
);

   localparam int unsigned CW = $clog2(BAUD_DIV) + 1;
   localparam logic [CW-1:0] FULL = CW'(BAUD_DIV - 1);

   logic          rd, rd_data, wr_data, wr_ctrl;
   logic [1:0]    ctrl_q;
   logic [7:0]    rx_data_q, status;
   logic          rx_full_q, ferr_q, ovr_q, tx_empty_q;
   logic [7:0]    rx_byte;
   logic          rx_valid, rx_ferr;

   frame_state_t  state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [2:0]    bit_q, bit_d;
   logic [7:0]    shift_q, shift_d;
   logic          tx_empty_d, tx_d;

   assign rd      = cs & ~we;
   assign rd_data = rd & (rs == ACIA_REG_DATA);
   assign wr_data = cs & we & (rs == ACIA_REG_DATA);
   assign wr_ctrl = cs & we & (rs == ACIA_REG_STAT);

   always_comb begin
      status                = '0;
      status[STAT_RX_FULL]  = rx_full_q;
      status[STAT_TX_EMPTY] = tx_empty_q;
      status[STAT_FERR]     = ferr_q;
      status[STAT_OVR]      = ovr_q;
      status[STAT_IRQ]      = irq;
   end

   uart_rx_core #(.BAUD_DIV(BAUD_DIV)) u_rx (
      .clk      (clk),
      .reset    (reset),
      .rx       (rx),
      .rx_byte  (rx_byte),
      .rx_valid (rx_valid),
      .rx_ferr  (rx_ferr)
   );

   // tx is registered from the next state so it changes on the same edge as the FSM
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      bit_d      = bit_q;
      shift_d    = shift_q;
      tx_empty_d = tx_empty_q;
      if (state_q == ST_IDLE) begin
         if (wr_data) begin
            state_d    = ST_START;
            cnt_d      = FULL;
            shift_d    = din;
            tx_empty_d = 1'b0;
         end
      end else if (cnt_q != '0) begin
         cnt_d = cnt_q - CW'(1);
      end else begin
         cnt_d = FULL;
         case (state_q)
            ST_START: begin
               state_d = ST_DATA;
               bit_d   = '0;
            end
            ST_DATA: begin
               shift_d = {1'b0, shift_q[7:1]};
               if (bit_q == 3'd7) state_d = ST_STOP;
               else bit_d = bit_q + 3'd1;
            end
            ST_STOP: begin
               state_d    = ST_IDLE;
               tx_empty_d = 1'b1;
            end
            default: state_d = ST_IDLE;
         endcase
      end
      case (state_d)
         ST_START: tx_d = 1'b0;
         ST_DATA:  tx_d = shift_d[0];
         default:  tx_d = 1'b1;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= ST_IDLE;
         cnt_q      <= '0;
         bit_q      <= '0;
         shift_q    <= '0;
         tx_empty_q <= 1'b1;
         tx         <= 1'b1;
         dout       <= '0;
         ctrl_q     <= '0;
         rx_data_q  <= '0;
         rx_full_q  <= 1'b0;
         ferr_q     <= 1'b0;
         ovr_q      <= 1'b0;
         irq        <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         bit_q      <= bit_d;
         shift_q    <= shift_d;
         tx_empty_q <= tx_empty_d;
         tx         <= tx_d;
         if (rd) dout <= (rs == ACIA_REG_STAT) ? status : rx_data_q;
         if (rd_data) begin
            rx_full_q <= 1'b0;
            ovr_q     <= 1'b0;
         end
         // A read on the completion edge frees the slot, so the new byte lands
         if (rx_valid) begin
            ferr_q <= rx_ferr;
            if (rx_full_q && !rd_data) ovr_q <= 1'b1;
            else begin
               rx_data_q <= rx_byte;
               rx_full_q <= 1'b1;
            end
         end
         if (wr_ctrl) ctrl_q <= din[1:0];
         irq <= (ctrl_q[CTRL_RX_IRQ_EN] & rx_full_q) | (ctrl_q[CTRL_TX_IRQ_EN] & tx_empty_q);
      end
   end

endmodule

// File: tb/tb_acia_uart.sv
// Directed self-checking bench for acia_uart at 8 clocks per bit.
module tb_acia_uart;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       cs = 1'b0;
   logic       we = 1'b0;
   logic       rs = 1'b0;
   logic [7:0] din = '0;
   logic [7:0] dout;
   logic       rx = 1'b1;
   logic       tx;
   logic       irq;

   int unsigned tests = 0;
   int unsigned fails = 0;

   acia_uart #(.BAUD_DIV(8)) dut (
      .clk   (clk),
      .reset (reset),
      .cs    (cs),
      .we    (we),
      .rs    (rs),
      .din   (din),
      .dout  (dout),
      .rx    (rx),
      .tx    (tx),
      .irq   (irq)
   );

   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic cyc(input int unsigned n);
      repeat (n) @(negedge clk);
   endtask

   task automatic bus_write(input logic r, input logic [7:0] d);
      cs = 1'b1; we = 1'b1; rs = r; din = d;
      @(negedge clk);
      cs = 1'b0; we = 1'b0;
   endtask

   task automatic bus_read(input logic r, output logic [7:0] d);
      cs = 1'b1; we = 1'b0; rs = r;
      @(negedge clk);
      cs = 1'b0;
      d = dout;
   endtask

   // Drives one 8N1 frame; with coll set, a DATA read is issued so it lands on
   // the edge where the receiver hands this byte to the register file.
   task automatic send_byte(input logic [7:0] b, input logic stop, input logic coll,
                            output logic [7:0] d);
      d = '0;
      rx = 1'b0;
      cyc(8);
      for (int i = 0; i < 8; i++) begin
         rx = b[i];
         cyc(8);
      end
      rx = stop;
      if (coll) begin
         cyc(7);
         bus_read(1'b1, d);
      end else begin
         cyc(8);
      end
      rx = 1'b1;
   endtask

   initial begin
      logic [7:0] d;
      logic [7:0] pat;
      int unsigned lows;

      @(negedge clk);
      cyc(3);
      reset = 1'b0;
      cyc(1);
      check("reset_tx", {7'd0, tx}, 8'h01);
      check("reset_irq", {7'd0, irq}, 8'h00);

      // 1: reset in the middle of a frame
      bus_write(1'b1, 8'h55);
      cyc(20);
      check("mid_frame_tx_low", {7'd0, tx}, 8'h00);
      reset = 1'b1;
      cyc(1);
      check("reset_mid_frame_tx", {7'd0, tx}, 8'h01);
      reset = 1'b0;
      bus_read(1'b0, d);
      check("reset_status", d, 8'h02);
      check("reset_irq_low", {7'd0, irq}, 8'h00);

      // 2: transmit $41, with a dropped write and a status read mid-frame
      pat = 8'h41;
      bus_write(1'b1, pat);
      cyc(4);
      check("tx_start_bit", {7'd0, tx}, 8'h00);
      for (int i = 0; i < 8; i++) begin
         if (i == 3) begin
            bus_write(1'b1, 8'hFF);
            cyc(7);
         end else if (i == 5) begin
            bus_read(1'b0, d);
            check("tx_busy_status", d, 8'h00);
            cyc(7);
         end else begin
            cyc(8);
         end
         check($sformatf("tx_bit%0d", i), {7'd0, tx}, {7'd0, pat[i]});
      end
      cyc(8);
      check("tx_stop_bit", {7'd0, tx}, 8'h01);
      cyc(4);
      bus_read(1'b0, d);
      check("tx_done_status", d, 8'h02);
      lows = 0;
      for (int i = 0; i < 100; i++) begin
         cyc(1);
         if (tx == 1'b0) lows++;
      end
      check("no_extra_frame", 8'(lows), 8'h00);

      // 3: receive $A5
      send_byte(8'hA5, 1'b1, 1'b0, d);
      cyc(2);
      bus_read(1'b0, d);
      check("rx_status_full", d, 8'h03);
      bus_read(1'b1, d);
      check("rx_data_a5", d, 8'hA5);
      bus_read(1'b0, d);
      check("rx_status_cleared", d, 8'h02);

      // 4: glitch, framing error, overrun
      rx = 1'b0;
      cyc(2);
      rx = 1'b1;
      cyc(20);
      bus_read(1'b0, d);
      check("glitch_no_byte", d, 8'h02);
      send_byte(8'h3C, 1'b0, 1'b0, d);
      cyc(2);
      bus_read(1'b0, d);
      check("ferr_status", d, 8'h07);
      bus_read(1'b1, d);
      check("ferr_data", d, 8'h3C);
      send_byte(8'h11, 1'b1, 1'b0, d);
      send_byte(8'h22, 1'b1, 1'b0, d);
      cyc(2);
      bus_read(1'b0, d);
      check("ovr_status", d, 8'h0B);
      bus_read(1'b1, d);
      check("ovr_keeps_first", d, 8'h11);
      bus_read(1'b0, d);
      check("ovr_cleared", d, 8'h02);

      // 5: interrupts
      bus_write(1'b0, 8'h01);
      send_byte(8'h5A, 1'b1, 1'b0, d);
      check("irq_lags_rx_full", {7'd0, irq}, 8'h00);
      cyc(1);
      check("irq_rx_set", {7'd0, irq}, 8'h01);
      bus_read(1'b1, d);
      check("irq_rx_data", d, 8'h5A);
      check("irq_held_on_read_edge", {7'd0, irq}, 8'h01);
      cyc(1);
      check("irq_rx_cleared", {7'd0, irq}, 8'h00);
      bus_write(1'b0, 8'h02);
      cyc(1);
      check("irq_tx_empty", {7'd0, irq}, 8'h01);
      bus_write(1'b0, 8'h00);
      cyc(2);
      check("irq_disabled", {7'd0, irq}, 8'h00);

      // 6: DATA read on the completion edge of a second byte
      send_byte(8'h11, 1'b1, 1'b0, d);
      cyc(2);
      send_byte(8'h22, 1'b1, 1'b1, d);
      check("coll_read_old", d, 8'h11);
      bus_read(1'b0, d);
      check("coll_status", d, 8'h03);
      bus_read(1'b1, d);
      check("coll_new_byte", d, 8'h22);
      bus_read(1'b0, d);
      check("coll_final_status", d, 8'h02);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
